// File: rtl/minhash_sort_ctrl.sv
// Controller that streams one set of signatures into an external min-k sorter,
// then captures the sorter's smallest indices and holds them for downstream.
module minhash_sort_ctrl #(
  parameter int INDICES_COUNT = 4,
  parameter int INDICE_LEN    = 6,
  parameter int SIGNATURE_LEN = 32,
  parameter int SET_LEN       = 64
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SIGNATURE_LEN-1:0]            in_signature,
  output logic [SIGNATURE_LEN-1:0]            srt_signature,
  output logic [INDICE_LEN-1:0]               srt_index,
  output logic                                srt_rst_n,
  output logic                                srt_end_sorting,
  input  logic [INDICES_COUNT*INDICE_LEN-1:0] srt_smallest_idx,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [INDICES_COUNT*INDICE_LEN-1:0] out_idx,
  output logic                                busy,
  output logic [15:0]                         sets_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DONE   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [INDICE_LEN-1:0] LAST_CNT = INDICE_LEN'(SET_LEN - 1);

  state_t                              state_r;
  state_t                              state_nxt_s;
  logic [INDICE_LEN-1:0]               cnt_r;
  logic [INDICES_COUNT*INDICE_LEN-1:0] out_idx_r;
  logic [15:0]                         sets_done_r;

  logic in_ready_r, busy_r, out_valid_r, srt_end_sorting_r, srt_rst_n_r;
  logic in_ready_nxt_s, busy_nxt_s, out_valid_nxt_s, srt_end_sorting_nxt_s, srt_rst_n_nxt_s;
  logic accept_s;

  // in_ready_r is high exactly while in FEED, so it doubles as the FEED qualifier
  assign accept_s = in_valid & in_ready_r;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort outranks the final-beat move to DONE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_CLEAR;
        else       state_nxt_s = S_IDLE;
      end
      S_CLEAR: begin
        if (abort) state_nxt_s = S_IDLE;
        else       state_nxt_s = S_FEED;
      end
      S_FEED: begin
        if (abort)                              state_nxt_s = S_IDLE;
        else if (accept_s && (cnt_r == LAST_CNT)) state_nxt_s = S_DONE;
        else                                    state_nxt_s = S_FEED;
      end
      S_DONE: begin
        if (abort) state_nxt_s = S_IDLE;
        else       state_nxt_s = S_RESULT;
      end
      S_RESULT: begin
        if (out_ready) state_nxt_s = S_IDLE;
        else           state_nxt_s = S_RESULT;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every control output is a flop
  always_comb begin
    in_ready_nxt_s        = (state_nxt_s == S_FEED);
    busy_nxt_s            = (state_nxt_s != S_IDLE);
    out_valid_nxt_s       = (state_nxt_s == S_RESULT);
    srt_end_sorting_nxt_s = (state_nxt_s == S_DONE);
    srt_rst_n_nxt_s       = (state_nxt_s != S_CLEAR);
  end

  // Control output registers; the sorter is held in clear while rst_n is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r        <= 1'b0;
      busy_r            <= 1'b0;
      out_valid_r       <= 1'b0;
      srt_end_sorting_r <= 1'b0;
      srt_rst_n_r       <= 1'b0;
    end else begin
      in_ready_r        <= in_ready_nxt_s;
      busy_r            <= busy_nxt_s;
      out_valid_r       <= out_valid_nxt_s;
      srt_end_sorting_r <= srt_end_sorting_nxt_s;
      srt_rst_n_r       <= srt_rst_n_nxt_s;
    end
  end

  // Beat counter: cleared in CLEAR, advances only on accepted beats
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {INDICE_LEN{1'b0}};
    end else if (state_r == S_CLEAR) begin
      cnt_r <= {INDICE_LEN{1'b0}};
    end else if (accept_s) begin
      cnt_r <= cnt_r + {{(INDICE_LEN-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Result capture at the end of DONE (skipped when the set is aborted there)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_idx_r <= {(INDICES_COUNT*INDICE_LEN){1'b0}};
    end else if ((state_r == S_DONE) && !abort) begin
      out_idx_r <= srt_smallest_idx;
    end else begin
      out_idx_r <= out_idx_r;
    end
  end

  // Delivered-result counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sets_done_r <= 16'd0;
    end else if ((state_r == S_RESULT) && out_ready) begin
      sets_done_r <= sets_done_r + 16'd1;
    end else begin
      sets_done_r <= sets_done_r;
    end
  end

  // Sorter feed: idle cycles present an all-ones signature that can never win
  always_comb begin
    if (accept_s) begin
      srt_signature = in_signature;
      srt_index     = cnt_r;
    end else begin
      srt_signature = {SIGNATURE_LEN{1'b1}};
      srt_index     = {INDICE_LEN{1'b0}};
    end
  end

  assign in_ready        = in_ready_r;
  assign busy            = busy_r;
  assign out_valid       = out_valid_r;
  assign srt_end_sorting = srt_end_sorting_r;
  assign srt_rst_n       = srt_rst_n_r;
  assign out_idx         = out_idx_r;
  assign sets_done       = sets_done_r;

endmodule

// File: tb/tb_minhash_sort_ctrl.sv
// Bench for minhash_sort_ctrl: a queue-based sorter model stands in for the
// external sorter, and expected results come from ranking the sent signatures.
module tb_minhash_sort_ctrl;

  localparam int IC   = 4;
  localparam int IL   = 6;
  localparam int SL   = 32;
  localparam int SETL = 8;
  localparam int OW   = IC * IL;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, in_valid, out_ready;
  logic          in_ready, srt_rst_n, srt_end_sorting, out_valid, busy;
  logic [SL-1:0] in_signature, srt_signature;
  logic [IL-1:0] srt_index;
  logic [OW-1:0] srt_smallest_idx, out_idx;
  logic [15:0]   sets_done;

  int n_cmp = 0;
  int n_err = 0;
  int exp_sets = 0;
  int unsigned sorter_sig[$];
  int unsigned sorter_idx[$];

  minhash_sort_ctrl #(
    .INDICES_COUNT(IC), .INDICE_LEN(IL), .SIGNATURE_LEN(SL), .SET_LEN(SETL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_signature(in_signature),
    .srt_signature(srt_signature), .srt_index(srt_index), .srt_rst_n(srt_rst_n),
    .srt_end_sorting(srt_end_sorting), .srt_smallest_idx(srt_smallest_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .busy(busy), .sets_done(sets_done)
  );

  always #5 clk = ~clk;

  // Smallest IC entries: ascending signature, later index first on ties
  function automatic logic [OW-1:0] top_k(input int unsigned sq[$], input int unsigned iq[$]);
    logic [OW-1:0] r;
    bit used[];
    int best;
    r = '0;
    used = new[sq.size()];
    for (int k = 0; k < IC; k++) begin
      best = -1;
      for (int j = 0; j < sq.size(); j++) begin
        if (!used[j] && (best < 0 || sq[j] < sq[best] ||
            (sq[j] == sq[best] && iq[j] > iq[best])))
          best = j;
      end
      if (best >= 0) begin
        used[best] = 1'b1;
        r[k*IL +: IL] = IL'(iq[best]);
      end
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] ref_result(input int unsigned sigs[$]);
    int unsigned idx[$];
    for (int i = 0; i < sigs.size(); i++) idx.push_back(i);
    return top_k(sigs, idx);
  endfunction

  // Sorter stand-in: clears on srt_rst_n, records every non-idle beat
  always @(posedge clk) begin
    if (srt_rst_n === 1'b0) begin
      sorter_sig.delete();
      sorter_idx.delete();
    end else if (srt_rst_n === 1'b1 && srt_signature !== {SL{1'b1}}) begin
      sorter_sig.push_back(srt_signature);
      sorter_idx.push_back(int'(srt_index));
    end
    srt_smallest_idx <= top_k(sorter_sig, sorter_idx);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (cycles) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_srt_rst_n", srt_rst_n, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_sets_done", sets_done, 0);
    check_eq("rst_end_sorting", srt_end_sorting, 0);
    exp_sets = 0;
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_srt_rst_n", srt_rst_n, 1);
    check_eq("post_rst_busy", busy, 0);
  endtask

  task automatic start_set();
    start = 1'b1;
    tick();
    check_eq("clear_srt_rst_n", srt_rst_n, 0);
    check_eq("clear_busy", busy, 1);
    check_eq("clear_in_ready", in_ready, 0);
    start = 1'b0;
    tick();
    check_eq("feed_srt_rst_n", srt_rst_n, 1);
    check_eq("feed_in_ready", in_ready, 1);
  endtask

  task automatic feed_beat(input int unsigned sig, input int idx, input int gap, input bit ab);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      start = 1'($urandom_range(1, 0));
      #1;
      check_eq("gap_srt_sig", srt_signature, {SL{1'b1}});
      check_eq("gap_srt_idx", srt_index, 0);
      tick();
      check_eq("gap_in_ready", in_ready, 1);
    end
    start = 1'b0;
    in_valid = 1'b1;
    in_signature = sig;
    abort = ab;
    #1;
    check_eq("beat_srt_sig", srt_signature, sig);
    check_eq("beat_srt_idx", srt_index, idx);
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic finish_set(input logic [OW-1:0] exp, input int delay);
    check_eq("done_end_sorting", srt_end_sorting, 1);
    check_eq("done_out_valid", out_valid, 0);
    check_eq("done_in_ready", in_ready, 0);
    tick();
    check_eq("res_out_valid", out_valid, 1);
    check_eq("res_end_sorting", srt_end_sorting, 0);
    check_eq("res_out_idx", out_idx, exp);
    for (int d = 0; d < delay; d++) begin
      start = 1'($urandom_range(1, 0));
      abort = 1'($urandom_range(1, 0));
      tick();
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_out_idx", out_idx, exp);
    end
    start = 1'b0;
    abort = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_sets++;
    check_eq("ack_out_valid", out_valid, 0);
    check_eq("ack_busy", busy, 0);
    check_eq("ack_sets_done", sets_done, exp_sets);
  endtask

  task automatic run_set(input int unsigned sigs[$], input int gap_min, input int gap_max,
                         input int delay);
    start_set();
    for (int i = 0; i < sigs.size(); i++)
      feed_beat(sigs[i], i, $urandom_range(gap_max, gap_min), 1'b0);
    finish_set(ref_result(sigs), delay);
  endtask

  task automatic check_aborted();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_end_sorting", srt_end_sorting, 0);
    check_eq("abort_sets_done", sets_done, exp_sets);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned sigs[$];
    logic [OW-1:0] want;
    in_signature = '0;
    apply_reset(2);

    // Distinct signatures, no stalls
    sigs = '{50, 10, 40, 20, 80, 30, 70, 60};
    run_set(sigs, 0, 0, 0);
    want = {6'd2, 6'd5, 6'd3, 6'd1};
    check_eq("dir_distinct_idx", out_idx, want);
    check_eq("dir_distinct_sets", sets_done, 1);

    // All equal: later indices take the lower slots
    sigs = '{7, 7, 7, 7, 7, 7, 7, 7};
    run_set(sigs, 0, 0, 0);
    want = {6'd4, 6'd5, 6'd6, 6'd7};
    check_eq("dir_ties_idx", out_idx, want);

    // Three-cycle input gaps and a four-cycle downstream stall
    sigs = '{50, 10, 40, 20, 80, 30, 70, 60};
    run_set(sigs, 3, 3, 4);

    // Abort after three beats; leaked low signatures would change the result
    start_set();
    for (int i = 0; i < 3; i++) feed_beat(0, i, 0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_aborted();
    sigs = '{90, 80, 70, 60, 50, 40, 30, 20};
    run_set(sigs, 0, 1, 1);
    want = {6'd4, 6'd5, 6'd6, 6'd7};
    check_eq("abort_new_set_idx", out_idx, want);

    // Abort in CLEAR
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_aborted();
    check_eq("abort_clear_srt_rst_n", srt_rst_n, 1);

    // Abort together with the final beat beats the move to DONE
    start_set();
    for (int i = 0; i < SETL - 1; i++) feed_beat(i + 1, i, 0, 1'b0);
    feed_beat(3, SETL - 1, 0, 1'b1);
    check_aborted();

    // Abort in DONE: no result delivered, previous capture kept
    start_set();
    for (int i = 0; i < SETL; i++) feed_beat(100 - i, i, 0, 1'b0);
    check_eq("done_abort_end_sorting", srt_end_sorting, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_aborted();
    check_eq("done_abort_out_idx", out_idx, want);

    // Reset in the middle of FEED, then a clean set
    start_set();
    feed_beat(5, 0, 0, 1'b0);
    feed_beat(6, 1, 0, 1'b0);
    apply_reset(1);
    sigs = '{3, 9, 1, 4, 1, 5, 9, 2};
    run_set(sigs, 0, 2, 2);

    // Randomized sets with a narrow value range to provoke ties
    for (int s = 0; s < 8; s++) begin
      sigs.delete();
      for (int i = 0; i < SETL; i++) sigs.push_back($urandom_range(15, 0));
      run_set(sigs, 0, 3, $urandom_range(4, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
